bp_be_pipe_sys_seq: RTL and testbench

Parametrised successor system pipe for the BE calculator. It carries CSR commands through a configurable-depth pipeline with per-stage kill, and arbitrates them against memory-pipe exception and TLB-miss events held in a one-entry event buffer. It issues one command per handshake to a CSR file that may back-pressure, and returns a registered response.

---
 rtl/bp_be_pkg.sv | 52 +++++
 rtl/bsg_dff_reset_en.sv | 16 +
 rtl/bp_be_pipe_sys_seq.sv | 141 ++++++++++++++
 tb/tb_bp_be_pipe_sys_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared BE definitions: CSR functional-unit ops, the CSR command layout and
// the exception-source to op mapping used by the system pipe's event buffer.
package bp_be_pkg;

  typedef enum logic [4:0] {
    e_csrrw                  = 5'd0,
    e_csrrs                  = 5'd1,
    e_csrrc                  = 5'd2,
    e_csrrwi                 = 5'd3,
    e_csrrsi                 = 5'd4,
    e_csrrci                 = 5'd5,
    e_dtlb_fill              = 5'd6,
    e_op_load_page_fault     = 5'd7,
    e_op_store_page_fault    = 5'd8,
    e_op_load_misaligned     = 5'd9,
    e_op_store_misaligned    = 5'd10,
    e_op_load_access_fault   = 5'd11,
    e_op_store_access_fault  = 5'd12,
    e_op_instr_page_fault    = 5'd13,
    e_op_instr_access_fault  = 5'd14
  } bp_be_csr_fu_op_e;

  typedef struct packed {
    bp_be_csr_fu_op_e op;
    logic [11:0]      addr;
    logic [63:0]      data;
  } bp_be_csr_cmd_s;

  localparam int bp_be_csr_cmd_width = $bits(bp_be_csr_cmd_s);

  localparam int exc_op_num_lp = 8;

  // Index 0 is the highest-priority exception source.
  localparam bp_be_csr_fu_op_e exc_op_table [exc_op_num_lp] = '{
    e_op_load_page_fault,
    e_op_store_page_fault,
    e_op_load_misaligned,
    e_op_store_misaligned,
    e_op_load_access_fault,
    e_op_store_access_fault,
    e_op_instr_page_fault,
    e_op_instr_access_fault
  };

  // Sources beyond the table fold onto the lowest-priority fault.
  function automatic bp_be_csr_fu_op_e exc_op(input int idx);
    exc_op = e_op_instr_access_fault;
    for (int i = 0; i < exc_op_num_lp; i++)
      if (i == idx) exc_op = exc_op_table[i];
  endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high clear.
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i)
    if (reset_i)   data_o <= '0;
    else if (en_i) data_o <= data_i;

endmodule

// File: rtl/bp_be_pipe_sys_seq.sv
// System pipe: CSR commands flow through a killable shift pipeline and are
// arbitrated against a one-entry memory-event buffer onto a CSR-file handshake.
module bp_be_pipe_sys_seq
  import bp_be_pkg::*;
#(
  parameter int stages_p       = 2,
  parameter int dword_width_p  = 64,
  parameter int vaddr_width_p  = 39,
  parameter int num_exc_p      = 8,
  parameter int csr_op_width_p = 5,
  localparam int cmd_width_lp  = csr_op_width_p + 12 + dword_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      v_i,
  input  logic [csr_op_width_p-1:0] csr_op_i,
  input  logic [11:0]               csr_addr_i,
  input  logic [dword_width_p-1:0]  rs1_i,
  input  logic [dword_width_p-1:0]  imm_i,
  output logic                      stall_o,
  input  logic [stages_p-1:0]       kill_i,

  input  logic                      evt_v_i,
  input  logic                      tlb_miss_i,
  input  logic [num_exc_p-1:0]      exc_i,
  input  logic [vaddr_width_p-1:0]  exc_vaddr_i,
  output logic                      evt_ready_o,

  output logic                      csr_cmd_v_o,
  output logic [cmd_width_lp-1:0]   csr_cmd_o,
  input  logic                      csr_cmd_ready_i,
  input  logic [dword_width_p-1:0]  csr_data_i,
  input  logic                      csr_exc_i,

  output logic                      resp_v_o,
  output logic                      resp_evt_o,
  output logic [dword_width_p-1:0]  data_o,
  output logic                      exc_v_o,
  output logic                      miss_v_o
);

  localparam logic [csr_op_width_p-1:0] op_dtlb_fill_lp = csr_op_width_p'(e_dtlb_fill);

  logic [stages_p-1:0]                   vld_pipe;
  logic [stages_p-1:0][cmd_width_lp-1:0] stage_cmd;
  logic                                  commit_v, adv, pipe_accept, accept, issue, use_imm;
  logic [cmd_width_lp-1:0]               issue_cmd;

  logic                                  evt_v_r, evt_load;
  logic [cmd_width_lp-1:0]               evt_cmd_r;
  logic [csr_op_width_p-1:0]             evt_op, cmd_op;

  // Pipeline control
  assign commit_v    = vld_pipe[stages_p-1];
  assign pipe_accept = commit_v & ~evt_v_r & csr_cmd_ready_i;
  assign adv         = ~commit_v | pipe_accept;
  assign stall_o     = ~adv;
  assign issue       = v_i & ~stall_o;

  assign use_imm   = (csr_op_i == csr_op_width_p'(e_csrrwi))
                   | (csr_op_i == csr_op_width_p'(e_csrrsi))
                   | (csr_op_i == csr_op_width_p'(e_csrrci));
  assign issue_cmd = {csr_op_i, csr_addr_i, use_imm ? imm_i : rs1_i};

  for (genvar k = 0; k < stages_p; k++) begin : stg
    logic                    vld_in;
    logic [cmd_width_lp-1:0] cmd_in;

    if (k == 0) begin : head
      assign vld_in = issue;
      assign cmd_in = issue_cmd;
    end else begin : body
      // A kill on the upstream stage travels with the entry as it shifts.
      assign vld_in = vld_pipe[k-1] & ~kill_i[k-1];
      assign cmd_in = stage_cmd[k-1];
    end

    bsg_dff_reset_en #(.width_p(1)) vld_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (1'b1),
      .data_i  (adv ? vld_in : (vld_pipe[k] & ~kill_i[k])),
      .data_o  (vld_pipe[k])
    );

    bsg_dff_reset_en #(.width_p(cmd_width_lp)) cmd_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (adv),
      .data_i  (cmd_in),
      .data_o  (stage_cmd[k])
    );
  end

  // Event buffer: TLB miss wins, else the lowest-index exception source.
  always_comb begin
    evt_op = op_dtlb_fill_lp;
    if (!tlb_miss_i)
      for (int i = num_exc_p - 1; i >= 0; i--)
        if (exc_i[i]) evt_op = csr_op_width_p'(exc_op(i));
  end

  assign evt_load    = evt_v_i & ~evt_v_r & (tlb_miss_i | (|exc_i));
  assign evt_ready_o = ~evt_v_r;

  always_ff @(posedge clk_i)
    if (reset_i) begin
      evt_v_r   <= 1'b0;
      evt_cmd_r <= '0;
    end else if (evt_load) begin
      evt_v_r   <= 1'b1;
      evt_cmd_r <= {evt_op, 12'h000, dword_width_p'(exc_vaddr_i)};
    end else if (evt_v_r & csr_cmd_ready_i) begin
      evt_v_r   <= 1'b0;
    end

  // Arbitration and response
  assign csr_cmd_v_o = evt_v_r | commit_v;
  assign csr_cmd_o   = evt_v_r ? evt_cmd_r : stage_cmd[stages_p-1];
  assign accept      = csr_cmd_v_o & csr_cmd_ready_i;
  assign cmd_op      = csr_cmd_o[cmd_width_lp-1 -: csr_op_width_p];

  always_ff @(posedge clk_i)
    if (reset_i) begin
      resp_v_o   <= 1'b0;
      resp_evt_o <= 1'b0;
      miss_v_o   <= 1'b0;
      data_o     <= '0;
      exc_v_o    <= 1'b0;
    end else begin
      resp_v_o   <= accept;
      resp_evt_o <= accept & evt_v_r;
      miss_v_o   <= accept & (cmd_op == op_dtlb_fill_lp);
      if (accept) begin
        data_o  <= csr_data_i;
        exc_v_o <= csr_exc_i;
      end
    end

endmodule

// File: tb/tb_bp_be_pipe_sys_seq.sv
// Bench for bp_be_pipe_sys_seq: table-driven issue vectors, directed corner
// sequences, then random traffic against an ordered-transaction model.
module tb_bp_be_pipe_sys_seq;

  localparam int S  = 2;
  localparam int CW = 5 + 12 + 64;
  localparam logic [4:0] OP_DTLB = 5'd6;
  localparam logic [4:0] EXC_TAB [8] = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};

  logic          clk = 1'b0;
  logic          reset_i, v_i, evt_v_i, tlb_miss_i, evt_ready_o, stall_o;
  logic [4:0]    csr_op_i;
  logic [11:0]   csr_addr_i;
  logic [63:0]   rs1_i, imm_i, csr_data_i, data_o;
  logic [S-1:0]  kill_i;
  logic [7:0]    exc_i;
  logic [38:0]   exc_vaddr_i;
  logic          csr_cmd_v_o, csr_cmd_ready_i, csr_exc_i;
  logic [CW-1:0] csr_cmd_o;
  logic          resp_v_o, resp_evt_o, exc_v_o, miss_v_o;

  always #5 clk = ~clk;

  bp_be_pipe_sys_seq #(.stages_p(S)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .rs1_i(rs1_i), .imm_i(imm_i),
    .stall_o(stall_o), .kill_i(kill_i),
    .evt_v_i(evt_v_i), .tlb_miss_i(tlb_miss_i), .exc_i(exc_i), .exc_vaddr_i(exc_vaddr_i),
    .evt_ready_o(evt_ready_o),
    .csr_cmd_v_o(csr_cmd_v_o), .csr_cmd_o(csr_cmd_o), .csr_cmd_ready_i(csr_cmd_ready_i),
    .csr_data_i(csr_data_i), .csr_exc_i(csr_exc_i),
    .resp_v_o(resp_v_o), .resp_evt_o(resp_evt_o), .data_o(data_o), .exc_v_o(exc_v_o),
    .miss_v_o(miss_v_o)
  );

  int checks = 0, errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [4:0] op, input logic [11:0] a, input logic [63:0] d);
    return {op, a, d};
  endfunction

  function automatic logic [4:0] model_op(input logic tlb, input logic [7:0] exc);
    if (tlb) return OP_DTLB;
    for (int i = 0; i < 8; i++) if (exc[i]) return EXC_TAB[i];
    return 5'd0;
  endfunction

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [11:0] a, input logic [63:0] rs1, input logic [63:0] imm);
    v_i = 1'b1; csr_op_i = op; csr_addr_i = a; rs1_i = rs1; imm_i = imm;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [11:0] addr;
    logic [63:0] rs1, imm, rdata, exp_d;
    logic        cexc;
  } vec_t;

  vec_t vecs [6];

  logic [CW-1:0] pq [$];
  logic          m_full, e_v, e_evt, e_miss, e_exc, acc, load, quiet;
  logic [CW-1:0] m_evt;
  logic [63:0]   e_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op:5'd0, addr:12'h300, rs1:64'h8,                imm:64'h0,  rdata:64'h1800, exp_d:64'h8,                cexc:1'b0};
    vecs[1] = '{op:5'd4, addr:12'h300, rs1:64'hFFFF,             imm:64'h1F, rdata:64'h2A,   exp_d:64'h1F,               cexc:1'b0};
    vecs[2] = '{op:5'd1, addr:12'h341, rs1:64'hDEADBEEF_12345678, imm:64'h5,  rdata:64'hFACE, exp_d:64'hDEADBEEF_12345678, cexc:1'b1};
    vecs[3] = '{op:5'd5, addr:12'hFFF, rs1:64'h77,               imm:64'h3,  rdata:64'h0,    exp_d:64'h3,                cexc:1'b0};
    vecs[4] = '{op:5'd2, addr:12'h001, rs1:64'hFFFF_FFFF_FFFF_FFFF, imm:64'h1, rdata:64'h99, exp_d:64'hFFFF_FFFF_FFFF_FFFF, cexc:1'b0};
    vecs[5] = '{op:5'd3, addr:12'h7C0, rs1:64'h1234,             imm:64'h10, rdata:64'h5A5A, exp_d:64'h10,               cexc:1'b1};

    reset_i = 1'b1; v_i = 1'b0; csr_op_i = '0; csr_addr_i = '0; rs1_i = '0; imm_i = '0;
    kill_i = '0; evt_v_i = 1'b0; tlb_miss_i = 1'b0; exc_i = '0; exc_vaddr_i = '0;
    csr_cmd_ready_i = 1'b0; csr_data_i = '0; csr_exc_i = 1'b0;
    repeat (3) next();

    // Reset state
    @(negedge clk);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_evt_ready", evt_ready_o, 1'b1);
    chk1("rst_cmd_v", csr_cmd_v_o, 1'b0);
    chkw("rst_cmd", 128'(csr_cmd_o), 128'(0));
    chk1("rst_resp_v", resp_v_o, 1'b0);
    chkw("rst_resp_bits", 128'({resp_evt_o, exc_v_o, miss_v_o}), 128'(0));
    chkw("rst_data", 128'(data_o), 128'(0));
    next();
    reset_i = 1'b0;
    next();

    // Table-driven single commands: latency, operand select, response capture
    foreach (vecs[i]) begin
      csr_cmd_ready_i = 1'b1;
      drive_issue(vecs[i].op, vecs[i].addr, vecs[i].rs1, vecs[i].imm);
      @(negedge clk); chk1("vec_issue_stall", stall_o, 1'b0);
      next(); v_i = 1'b0;
      @(negedge clk); chk1("vec_lat_cmd_v", csr_cmd_v_o, 1'b0);
      next(); csr_data_i = vecs[i].rdata; csr_exc_i = vecs[i].cexc;
      @(negedge clk);
      chk1("vec_cmd_v", csr_cmd_v_o, 1'b1);
      chkw("vec_cmd", 128'(csr_cmd_o), 128'(mk(vecs[i].op, vecs[i].addr, vecs[i].exp_d)));
      next(); csr_data_i = '0; csr_exc_i = 1'b0;
      @(negedge clk);
      chk1("vec_resp_v", resp_v_o, 1'b1);
      chkw("vec_resp_data", 128'(data_o), 128'(vecs[i].rdata));
      chk1("vec_resp_exc", exc_v_o, vecs[i].cexc);
      chkw("vec_resp_evt_miss", 128'({resp_evt_o, miss_v_o}), 128'(0));
      chk1("vec_cmd_v_after", csr_cmd_v_o, 1'b0);
      next();
    end
    @(negedge clk);
    chk1("hold_resp_v", resp_v_o, 1'b0);
    chkw("hold_data", 128'(data_o), 128'(vecs[5].rdata));

    // Back-pressure: two commands held, then accepted in order
    next();
    csr_cmd_ready_i = 1'b0;
    drive_issue(5'd0, 12'h340, 64'hA1, 64'h0);
    next(); drive_issue(5'd1, 12'h341, 64'hB2, 64'h0);
    @(negedge clk); chk1("bp_no_stall_yet", stall_o, 1'b0);
    next(); v_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("bp_stall", stall_o, 1'b1);
      chkw("bp_hold_cmd", 128'(csr_cmd_o), 128'(mk(5'd0, 12'h340, 64'hA1)));
      next();
    end
    csr_cmd_ready_i = 1'b1; csr_data_i = 64'h111;
    @(negedge clk);
    chk1("bp_release_stall", stall_o, 1'b0);
    chkw("bp_first", 128'(csr_cmd_o), 128'(mk(5'd0, 12'h340, 64'hA1)));
    next(); csr_data_i = 64'h222;
    @(negedge clk);
    chkw("bp_second", 128'(csr_cmd_o), 128'(mk(5'd1, 12'h341, 64'hB2)));
    chk1("bp_resp1_v", resp_v_o, 1'b1);
    chkw("bp_resp1_data", 128'(data_o), 128'(64'h111));
    next(); csr_cmd_ready_i = 1'b0;
    @(negedge clk);
    chk1("bp_resp2_v", resp_v_o, 1'b1);
    chkw("bp_resp2_data", 128'(data_o), 128'(64'h222));
    chk1("bp_empty", csr_cmd_v_o, 1'b0);
    next();

    // Kill the commit entry while stalled
    drive_issue(5'd2, 12'h342, 64'hC3, 64'h0);
    next(); drive_issue(5'd3, 12'h343, 64'h0, 64'hD4);
    next(); v_i = 1'b0;
    @(negedge clk); chk1("kill_pre_stall", stall_o, 1'b1);
    next(); kill_i = 2'b10;
    @(negedge clk); chk1("kill_cycle_cmd_v", csr_cmd_v_o, 1'b1);
    next(); kill_i = '0;
    @(negedge clk);
    chk1("kill_cmd_v_drop", csr_cmd_v_o, 1'b0);
    chk1("kill_stall_drop", stall_o, 1'b0);
    chk1("kill_no_resp", resp_v_o, 1'b0);
    next(); csr_cmd_ready_i = 1'b1; csr_data_i = 64'h333;
    @(negedge clk);
    chkw("kill_next_cmd", 128'(csr_cmd_o), 128'(mk(5'd3, 12'h343, 64'hD4)));
    chk1("kill_no_resp2", resp_v_o, 1'b0);
    next(); csr_cmd_ready_i = 1'b0;
    @(negedge clk);
    chk1("kill_resp_v", resp_v_o, 1'b1);
    chkw("kill_resp_data", 128'(data_o), 128'(64'h333));
    next();

    // Exception preempts a waiting commit entry
    drive_issue(5'd1, 12'h305, 64'hE5, 64'h0);
    next(); v_i = 1'b0;
    next(); evt_v_i = 1'b1; exc_i = 8'b0000_0110; exc_vaddr_i = 39'h40_0010_00;
    exc_vaddr_i = 39'h4000_1000;
    @(negedge clk);
    chkw("exc_pre_cmd", 128'(csr_cmd_o), 128'(mk(5'd1, 12'h305, 64'hE5)));
    next(); evt_v_i = 1'b0; exc_i = '0; csr_cmd_ready_i = 1'b1; csr_data_i = 64'h444;
    @(negedge clk);
    chkw("exc_cmd", 128'(csr_cmd_o), 128'(mk(EXC_TAB[1], 12'h000, 64'h4000_1000)));
    chk1("exc_evt_ready", evt_ready_o, 1'b0);
    chk1("exc_pipe_stall", stall_o, 1'b1);
    next(); csr_data_i = 64'h555;
    @(negedge clk);
    chk1("exc_resp_v", resp_v_o, 1'b1);
    chk1("exc_resp_evt", resp_evt_o, 1'b1);
    chkw("exc_resp_data", 128'(data_o), 128'(64'h444));
    chkw("exc_pipe_follows", 128'(csr_cmd_o), 128'(mk(5'd1, 12'h305, 64'hE5)));
    next(); csr_cmd_ready_i = 1'b0;
    @(negedge clk);
    chkw("exc_pipe_resp", 128'({resp_v_o, resp_evt_o}), 128'(2'b10));
    chkw("exc_pipe_resp_data", 128'(data_o), 128'(64'h555));
    next();

    // TLB miss beats exceptions; a second event while full is dropped
    evt_v_i = 1'b1; tlb_miss_i = 1'b1; exc_i = 8'h01; exc_vaddr_i = 39'h7F_0000_0123;
    @(negedge clk); chk1("tlb_ready_empty", evt_ready_o, 1'b1);
    next(); tlb_miss_i = 1'b0; exc_i = 8'h04; exc_vaddr_i = 39'h999;
    @(negedge clk);
    chk1("tlb_ready_full", evt_ready_o, 1'b0);
    chkw("tlb_cmd", 128'(csr_cmd_o), 128'(mk(OP_DTLB, 12'h000, 64'h7F_0000_0123)));
    next(); evt_v_i = 1'b0; exc_i = '0; csr_cmd_ready_i = 1'b1; csr_data_i = 64'h666; csr_exc_i = 1'b1;
    @(negedge clk);
    chkw("tlb_cmd_stable", 128'(csr_cmd_o), 128'(mk(OP_DTLB, 12'h000, 64'h7F_0000_0123)));
    next(); csr_cmd_ready_i = 1'b0; csr_exc_i = 1'b0;
    @(negedge clk);
    chkw("tlb_resp", 128'({resp_v_o, resp_evt_o, miss_v_o, exc_v_o}), 128'(4'b1111));
    chk1("tlb_dropped", csr_cmd_v_o, 1'b0);
    next(); evt_v_i = 1'b1;
    @(negedge clk); chk1("null_evt_ready", evt_ready_o, 1'b1);
    next(); evt_v_i = 1'b0;
    @(negedge clk);
    chk1("null_evt_ignored", csr_cmd_v_o, 1'b0);
    chk1("null_evt_miss", miss_v_o, 1'b0);
    next();

    // Reset with a pipeline entry and an event both pending
    drive_issue(5'd0, 12'h111, 64'hF0, 64'h0);
    evt_v_i = 1'b1; exc_i = 8'h80; exc_vaddr_i = 39'h1;
    next(); v_i = 1'b0; evt_v_i = 1'b0; exc_i = '0;
    @(negedge clk); chk1("mid_rst_pending", csr_cmd_v_o, 1'b1);
    next(); reset_i = 1'b1;
    next(); reset_i = 1'b0;
    @(negedge clk);
    chk1("mid_rst_cmd_v", csr_cmd_v_o, 1'b0);
    chk1("mid_rst_evt_ready", evt_ready_o, 1'b1);
    chkw("mid_rst_data", 128'(data_o), 128'(0));
    next();
    next();

    // Random traffic against an in-order transaction model
    m_full = 1'b0; e_v = 1'b0; e_evt = 1'b0; e_miss = 1'b0; e_exc = 1'b0; e_data = '0; m_evt = '0;
    for (int cyc = 0; cyc < 2020; cyc++) begin
      quiet           = (cyc >= 2000);
      csr_cmd_ready_i = quiet ? 1'b1 : ($urandom_range(0, 2) != 0);
      csr_data_i      = {$urandom, $urandom};
      csr_exc_i       = 1'($urandom_range(0, 1));
      evt_v_i         = !quiet && ($urandom_range(0, 5) == 0);
      tlb_miss_i      = ($urandom_range(0, 3) == 0);
      exc_i           = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h0;
      exc_vaddr_i     = 39'({$urandom, $urandom});
      csr_op_i        = 5'($urandom_range(0, 5));
      csr_addr_i      = 12'($urandom);
      rs1_i           = {$urandom, $urandom};
      imm_i           = 64'($urandom_range(0, 31));
      #1;
      v_i = !quiet && !stall_o && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      chk1("rnd_resp_v", resp_v_o, e_v);
      chkw("rnd_resp_bits", 128'({resp_evt_o, miss_v_o}), 128'(e_v ? {e_evt, e_miss} : 2'b00));
      if (e_v) begin
        chkw("rnd_resp_data", 128'(data_o), 128'(e_data));
        chk1("rnd_resp_exc", exc_v_o, e_exc);
      end
      chk1("rnd_evt_ready", evt_ready_o, !m_full);
      if (m_full) begin
        chk1("rnd_evt_cmd_v", csr_cmd_v_o, 1'b1);
        chkw("rnd_evt_cmd", 128'(csr_cmd_o), 128'(m_evt));
      end
      acc    = csr_cmd_v_o & csr_cmd_ready_i;
      load   = evt_v_i && !m_full && (tlb_miss_i || exc_i != 8'h0);
      e_v    = acc;
      e_data = csr_data_i;
      e_exc  = csr_exc_i;
      e_evt  = 1'b0;
      e_miss = 1'b0;
      if (acc) begin
        if (m_full) begin
          e_evt  = 1'b1;
          e_miss = (m_evt[CW-1 -: 5] == OP_DTLB);
          m_full = 1'b0;
        end else if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_spurious: got accepted cmd %0h expected no command", csr_cmd_o);
        end else begin
          chkw("rnd_pipe_cmd", 128'(csr_cmd_o), 128'(pq.pop_front()));
        end
      end
      if (v_i) pq.push_back(mk(csr_op_i, csr_addr_i, (csr_op_i >= 5'd3) ? imm_i : rs1_i));
      if (load) begin
        m_full = 1'b1;
        m_evt  = mk(model_op(tlb_miss_i, exc_i), 12'h000, 64'(exc_vaddr_i));
      end
      next();
    end
    v_i = 1'b0; evt_v_i = 1'b0;
    chkw("rnd_drain", 128'(pq.size()), 128'(0));
    chk1("rnd_evt_drain", m_full, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
